// File: rtl/prio_arbiter8_pkg.sv
// Shared types and constants for the eight-requester priority arbiter.
// Latency: n/a (types and a pure decode helper only).
// Backpressure: n/a.
package prio_arbiter8_pkg;

    localparam int ID_W  = 3;
    localparam int N_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Binary index to one-hot vector.
    function automatic logic [N_REQ-1:0] onehot8(input logic [ID_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_arbiter8_enc.sv
// Combinational 8-to-3 priority encoder, highest set index wins, plus valid flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_vec (request vector), o_idx (winning index), o_vld (any bit set).
module prio_enc8
    import prio_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] i_vec,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_vld
);

    always_comb begin
        o_idx = '0;
        o_vld = |i_vec;
        // Ascending scan: the last hit, i.e. the highest index, is kept.
        for (int i = 0; i < N_REQ; i++) begin
            if (i_vec[i]) begin
                o_idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_arbiter8.sv
// Eight-requester arbiter: registered active-low requests, single owner held until release or hold timeout.
// Latency: request to grant 2 cycles; release to next grant 3 cycles (one-cycle GAP between owners).
// Backpressure: ei_n high blocks new grants only; an owner keeps the resource until it releases or times out.
// Ports: clk, rst (sync, active-high), ei_n, req_n[7:0] in; gnt[7:0], gnt_id[2:0], gnt_valid,
//        gs_n, eo_n, timeout out -- all outputs registered.
module prio_arbiter8
    import prio_arbiter8_pkg::*;
#(
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             ei_n,
    input  logic [N_REQ-1:0] req_n,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             gs_n,
    output logic             eo_n,
    output logic             timeout
);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_req_q;
    logic [N_REQ-1:0] r_mask;
    logic [ID_W-1:0]  r_last;
    logic [ID_W-1:0]  r_owner;
    logic [7:0]       r_hold_cnt;
    logic [N_REQ-1:0] r_gnt;
    logic             r_gnt_valid;
    logic             r_gs_n;
    logic             r_eo_n;
    logic             r_timeout;

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_rot;
    logic [N_REQ-1:0] w_enc_in;
    logic [ID_W-1:0]  w_enc_idx;
    logic             w_enc_vld;
    logic [ID_W-1:0]  w_winner;
    logic             w_owner_req;
    logic             w_hold_max;
    logic             w_timeout_hit;
    logic [N_REQ-1:0] w_mask_set;

    assign w_elig = r_req_q & ~r_mask;

    // Rotate so that index (last-1) lands on bit 7 and last itself on bit 0;
    // the highest-wins encoder then gives the round-robin search order.
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_rot[j] = w_elig[ID_W'(j) + r_last];
        end
    end

    assign w_enc_in = (RR_MODE != 0) ? w_rot : w_elig;

    prio_enc8 u_enc (
        .i_vec (w_enc_in),
        .o_idx (w_enc_idx),
        .o_vld (w_enc_vld)
    );

    // Undo the rotation with mod-8 addition (3-bit wrap).
    assign w_winner = (RR_MODE != 0) ? (w_enc_idx + r_last) : w_enc_idx;

    assign w_owner_req   = r_req_q[r_owner];
    assign w_hold_max    = (r_hold_cnt == 8'(MAX_HOLD - 1));
    // Release wins over timeout when both land in the same cycle.
    assign w_timeout_hit = (r_state == GRANT) && w_owner_req && w_hold_max;
    assign w_mask_set    = w_timeout_hit ? onehot8(r_owner) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_q     <= '0;
            r_mask      <= '0;
            r_last      <= '0;
            r_owner     <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gs_n      <= 1'b1;
            r_eo_n      <= 1'b1;
            r_timeout   <= 1'b0;
        end else begin
            r_req_q   <= ~req_n;
            // A masked requester becomes eligible again once it has dropped.
            r_mask    <= (r_mask & r_req_q) | w_mask_set;
            r_gs_n    <= !(!ei_n && (w_elig != '0));
            r_eo_n    <= !(!ei_n && (w_elig == '0));
            r_timeout <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!ei_n && w_enc_vld) begin
                        r_owner     <= w_winner;
                        r_hold_cnt  <= '0;
                        r_gnt       <= onehot8(w_winner);
                        r_gnt_valid <= 1'b1;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!w_owner_req) begin
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_state     <= GAP;
                    end else if (w_hold_max) begin
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_state     <= GAP;
                    end else begin
                        r_hold_cnt  <= r_hold_cnt + 8'd1;
                    end
                end
                GAP: begin
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_owner;
    assign gnt_valid = r_gnt_valid;
    assign gs_n      = r_gs_n;
    assign eo_n      = r_eo_n;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_prio_arbiter8.sv
// Testbench for prio_arbiter8: three instances (fixed/16, round-robin/16, fixed/4) on shared inputs.
// Directed scenarios check literal expectations; a random phase checks every cycle against a reference model.
// Inputs are driven just after the falling edge and outputs sampled at the falling edge.
module tb_prio_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ei_n;
    logic [7:0] req_n;

    logic [7:0] gnt_fp, gnt_rr, gnt_to;
    logic [2:0] id_fp, id_rr, id_to;
    logic       vld_fp, vld_rr, vld_to;
    logic       gs_fp, gs_rr, gs_to;
    logic       eo_fp, eo_rr, eo_to;
    logic       to_fp, to_rr, to_to;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prio_arbiter8 #(.RR_MODE(0), .MAX_HOLD(16)) u_fp (
        .clk(clk), .rst(rst), .ei_n(ei_n), .req_n(req_n),
        .gnt(gnt_fp), .gnt_id(id_fp), .gnt_valid(vld_fp),
        .gs_n(gs_fp), .eo_n(eo_fp), .timeout(to_fp)
    );
    prio_arbiter8 #(.RR_MODE(1), .MAX_HOLD(16)) u_rr (
        .clk(clk), .rst(rst), .ei_n(ei_n), .req_n(req_n),
        .gnt(gnt_rr), .gnt_id(id_rr), .gnt_valid(vld_rr),
        .gs_n(gs_rr), .eo_n(eo_rr), .timeout(to_rr)
    );
    prio_arbiter8 #(.RR_MODE(0), .MAX_HOLD(4)) u_to (
        .clk(clk), .rst(rst), .ei_n(ei_n), .req_n(req_n),
        .gnt(gnt_to), .gnt_id(id_to), .gnt_valid(vld_to),
        .gs_n(gs_to), .eo_n(eo_to), .timeout(to_to)
    );

    // Observed output bundle per instance: {gnt, gnt_id, gnt_valid, gs_n, eo_n, timeout}.
    logic [14:0] obs [3];
    assign obs[0] = {gnt_fp, id_fp, vld_fp, gs_fp, eo_fp, to_fp};
    assign obs[1] = {gnt_rr, id_rr, vld_rr, gs_rr, eo_rr, to_rr};
    assign obs[2] = {gnt_to, id_to, vld_to, gs_to, eo_to, to_to};

    // ---------------- reference model ----------------
    int  P_HOLD [3] = '{16, 16, 4};
    bit  P_RR   [3] = '{1'b0, 1'b1, 1'b0};

    int       m_owner [3];
    int       m_last  [3];
    int       m_hold  [3];
    bit       m_busy  [3];
    bit       m_gap   [3];
    bit       m_to    [3];
    bit       m_gs    [3];
    bit       m_eo    [3];
    bit [7:0] m_reqq  [3];
    bit [7:0] m_mask  [3];

    always @(posedge clk) begin : model
        bit [7:0] elig;
        bit [7:0] setm;
        int       w;
        int       c;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_owner[k] = 0; m_last[k] = 0; m_hold[k] = 0;
                m_busy[k]  = 0; m_gap[k]  = 0; m_to[k]   = 0;
                m_gs[k]    = 1; m_eo[k]   = 1;
                m_reqq[k]  = 8'h00; m_mask[k] = 8'h00;
            end else begin
                elig     = m_reqq[k] & ~m_mask[k];
                setm     = 8'h00;
                m_gs[k]  = !(!ei_n && elig != 8'h00);
                m_eo[k]  = !(!ei_n && elig == 8'h00);
                m_to[k]  = 0;
                if (m_gap[k]) begin
                    m_last[k] = m_owner[k];
                    m_gap[k]  = 0;
                end else if (m_busy[k]) begin
                    if (!m_reqq[k][m_owner[k]]) begin
                        m_busy[k] = 0; m_gap[k] = 1;
                    end else if (m_hold[k] == P_HOLD[k] - 1) begin
                        setm[m_owner[k]] = 1'b1;
                        m_to[k] = 1; m_busy[k] = 0; m_gap[k] = 1;
                    end else begin
                        m_hold[k] = m_hold[k] + 1;
                    end
                end else if (!ei_n && elig != 8'h00) begin
                    w = -1;
                    if (P_RR[k]) begin
                        // Search last-1, last-2, ... down to last itself.
                        for (int s = 1; s <= 8; s++) begin
                            c = (m_last[k] - s + 8) % 8;
                            if (w < 0 && elig[c]) w = c;
                        end
                    end else begin
                        for (int i = 7; i >= 0; i--) begin
                            if (w < 0 && elig[i]) w = i;
                        end
                    end
                    m_owner[k] = w; m_hold[k] = 0; m_busy[k] = 1;
                end
                m_mask[k] = (m_mask[k] & m_reqq[k]) | setm;
                m_reqq[k] = ~req_n;
            end
        end
    end

    function automatic logic [14:0] exp_vec(int k);
        logic [7:0] g;
        g = m_busy[k] ? 8'(1 << m_owner[k]) : 8'h00;
        return {g, 3'(m_owner[k]), m_busy[k], m_gs[k], m_eo[k], m_to[k]};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; ei_n = 1'b1; req_n = 8'hFF;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs[k] !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state inst %0d: got %h want %h", k, obs[k], {8'h00, 3'd0, 4'b0110});
            end
            n_cmp++;
            if (obs[k] !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL reset_model inst %0d: got %h want %h", k, obs[k], exp_vec(k));
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fixed_priority();
        ei_n = 1'b0; req_n = 8'b1010_1111;
        tick(); tick();
        n_cmp++;
        if (gnt_fp !== 8'h40 || id_fp !== 3'd6) begin
            n_fail++;
            $display("FAIL fixed_prio: got gnt %h id %0d want 40 id 6", gnt_fp, id_fp);
        end
        // Owner 6 releases, requester 4 stays.
        req_n = 8'b1110_1111;
        tick();
        n_cmp++;
        if (gnt_fp !== 8'h40) begin
            n_fail++;
            $display("FAIL handoff_hold: got %h want 40", gnt_fp);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (gnt_fp !== 8'h00 || vld_fp !== 1'b0) begin
                n_fail++;
                $display("FAIL handoff_gap%0d: got gnt %h vld %b want 00 0", i, gnt_fp, vld_fp);
            end
        end
        tick();
        n_cmp++;
        if (gnt_fp !== 8'h10 || id_fp !== 3'd4 || vld_fp !== 1'b1) begin
            n_fail++;
            $display("FAIL handoff_next: got gnt %h id %0d want 10 id 4", gnt_fp, id_fp);
        end
        req_n = 8'hFF; ei_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_round_robin();
        int  e;
        bit  seen;
        rst = 1'b1; tick(); rst = 1'b0;
        ei_n = 1'b0; req_n = 8'h00;
        for (int g = 0; g < 9; g++) begin
            seen = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                tick();
                if (vld_rr) seen = 1;
            end
            e = (15 - g) % 8;
            n_cmp++;
            if (!seen || id_rr !== 3'(e) || gnt_rr !== 8'(1 << e)) begin
                n_fail++;
                $display("FAIL rr_seq%0d: got id %0d gnt %h seen %b want id %0d", g, id_rr, gnt_rr, seen, e);
            end
            req_n = 8'hFF; tick(); req_n = 8'h00;
        end
        req_n = 8'hFF; ei_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        int cnt;
        bit regrant;
        rst = 1'b1; tick(); rst = 1'b0;
        ei_n = 1'b0; req_n = 8'hF7;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (vld_to) cnt++;
            else if (cnt > 0) break;
        end
        n_cmp++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL to_len: got %0d grant cycles want 4", cnt);
        end
        n_cmp++;
        if (to_to !== 1'b1) begin
            n_fail++;
            $display("FAIL to_pulse: got %b want 1", to_to);
        end
        tick();
        n_cmp++;
        if (to_to !== 1'b0) begin
            n_fail++;
            $display("FAIL to_pulse_end: got %b want 0", to_to);
        end
        regrant = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (vld_to) regrant = 1;
        end
        n_cmp++;
        if (regrant !== 1'b0) begin
            n_fail++;
            $display("FAIL to_masked: got regrant %b want 0", regrant);
        end
        req_n = 8'hFF; tick(); req_n = 8'hF7;
        regrant = 0;
        for (int c = 0; c < 6 && !regrant; c++) begin
            tick();
            if (vld_to) regrant = 1;
        end
        n_cmp++;
        if (!regrant || id_to !== 3'd3) begin
            n_fail++;
            $display("FAIL to_unmask: got regrant %b id %0d want 1 id 3", regrant, id_to);
        end
        req_n = 8'hFF; ei_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_enable();
        rst = 1'b1; tick(); rst = 1'b0;
        ei_n = 1'b1; req_n = 8'h00;
        repeat (3) tick();
        n_cmp++;
        if (gnt_fp !== 8'h00 || gs_fp !== 1'b1 || eo_fp !== 1'b1) begin
            n_fail++;
            $display("FAIL en_off: got gnt %h gs %b eo %b want 00 1 1", gnt_fp, gs_fp, eo_fp);
        end
        ei_n = 1'b0; req_n = 8'hFF;
        repeat (2) tick();
        n_cmp++;
        if (eo_fp !== 1'b0 || gs_fp !== 1'b1) begin
            n_fail++;
            $display("FAIL en_empty: got eo %b gs %b want 0 1", eo_fp, gs_fp);
        end
        req_n = 8'hDF;
        repeat (2) tick();
        n_cmp++;
        if (gnt_fp !== 8'h20) begin
            n_fail++;
            $display("FAIL en_grant: got %h want 20", gnt_fp);
        end
        ei_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (gnt_fp !== 8'h20) begin
                n_fail++;
                $display("FAIL en_midgrant%0d: got %h want 20", c, gnt_fp);
            end
        end
        req_n = 8'hFF;
        repeat (3) tick();
        n_cmp++;
        if (gnt_fp !== 8'h00) begin
            n_fail++;
            $display("FAIL en_release: got %h want 00", gnt_fp);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_grant();
        bit seen;
        rst = 1'b1; tick(); rst = 1'b0;
        ei_n = 1'b0; req_n = 8'h00;
        for (int g = 0; g < 3; g++) begin
            seen = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                tick();
                if (vld_rr) seen = 1;
            end
            if (g < 2) begin
                req_n = 8'hFF; tick(); req_n = 8'h00;
            end
        end
        n_cmp++;
        if (id_rr !== 3'd5 || vld_rr !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_owner: got id %0d vld %b want 5 1", id_rr, vld_rr);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++;
        if (gnt_rr !== 8'h00 || vld_rr !== 1'b0 || gs_rr !== 1'b1 || eo_rr !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid: got gnt %h vld %b gs %b eo %b want 00 0 1 1", gnt_rr, vld_rr, gs_rr, eo_rr);
        end
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (vld_rr) seen = 1;
        end
        n_cmp++;
        if (!seen || id_rr !== 3'd7) begin
            n_fail++;
            $display("FAIL rst_rr_restart: got id %0d seen %b want 7", id_rr, seen);
        end
        req_n = 8'hFF; ei_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) req_n[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) req_n = 8'($urandom);
            if ($urandom_range(0, 9) == 0) ei_n = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 149) == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs[k] !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random inst %0d cyc %0d: got %h want %h", k, c, obs[k], exp_vec(k));
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_enable();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prio_arbiter8.md
# prio_arbiter8

Eight-requester arbiter that shares one resource, built around the 8-to-3 priority-encoding function already in the design. It registers active-low requests and grants exactly one owner at a time. Ownership is held until the owner releases or a hold timeout expires. It sits between eight request sources and the shared resource, and supplies one-hot and binary grant codes plus encoder-style group-status flags.

## Interface
- `RR_MODE`, default 0: 0 = fixed priority (index 7 highest); 1 = round-robin.
- `MAX_HOLD`, default 16: maximum GRANT cycles per ownership; legal range 2..255.
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ei_n` input 1: active-low enable. When high, no new grant is issued; a current grant runs to its normal end.
- `req_n` input 8: active-low requests; bit i belongs to requester i.
- `gnt` output 8: one-hot active-high grant; reset value 0.
- `gnt_id` output 3: binary index of the owner; valid only while `gnt_valid` is high; reset value 0.
- `gnt_valid` output 1: high while in GRANT; reset value 0.
- `gs_n` output 1: low when `ei_n`=0 and any unmasked request is pending; reset value 1.
- `eo_n` output 1: low when `ei_n`=0 and no unmasked request is pending; reset value 1.
- `timeout` output 1: one-cycle pulse when a grant is force-released; reset value 0.

## Operation
- `req_n` is registered once into `req_q` (active-high) before any decision is made.
- A request is eligible when `req_q[i]`=1 and `mask[i]`=0.
- The state machine has three states: IDLE, GRANT and GAP.
- IDLE:
  - If `ei_n`=0 and any request is eligible: select the winner, load `owner`, clear `hold_cnt`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - If `req_q[owner]`=0 (release), go to GAP.
  - Else if `hold_cnt`=MAX_HOLD-1, set `mask[owner]`, pulse `timeout`, go to GAP.
  - Otherwise increment `hold_cnt`.
  - Release takes priority when both conditions hit in the same cycle; no timeout is raised.
- GAP: lasts exactly one cycle with no grant. `last` is updated to `owner`, then the FSM returns to IDLE.
- Winner selection:
  - `RR_MODE`=0: the highest eligible index wins.
  - `RR_MODE`=1: search descending from (`last`-1) mod 8 and wrap; `last` itself is the lowest-priority candidate. `last` resets to 0, so index 7 is searched first after reset.
- Mask: `mask[i]` clears in any cycle where `req_q[i]`=0. This stops a timed-out requester from being re-granted until it has deasserted at least once.
- Outputs:
  - `gnt` = decode(`owner`) AND `gnt_valid`.
  - `gs_n` and `eo_n` are registered from the eligibility of `req_q`, with `ei_n` qualifying both.
- `ei_n` changing mid-GRANT has no effect on the current owner.

## Timing
- Request-to-grant latency is 2 cycles:
  - `req_n` falls before edge k.
  - `req_q` is set at edge k.
  - `gnt` is visible after edge k+1.
- Release-to-grant:
  - `req_n[owner]` rises before edge k, so `req_q` clears at edge k.
  - GAP begins at edge k+1.
  - IDLE at edge k+2.
  - The next `gnt` appears after edge k+3.
- Timeout case:
  - `gnt` drops after MAX_HOLD GRANT cycles.
  - `timeout` is high during the first GAP cycle only.
- Reset:
  - Synchronous, usable mid-GRANT.
  - State goes to IDLE; `gnt`, `gnt_valid` and `timeout` go to 0; `gs_n` and `eo_n` go to 1.
  - `req_q`, `mask`, `last` and `hold_cnt` are cleared.
- There is no combinational path from `req_n` or `ei_n` to any output.

## Structure
- Package `prio_arbiter8_pkg` holds:
  - state enum `arb_state_t` {IDLE, GRANT, GAP};
  - `ID_W`=3;
  - `N_REQ`=8.
- Sub-module `prio_enc8`: combinational 8-to-3 priority encoder with a valid flag. The round-robin path feeds it the eligible vector rotated by `last`; the result is un-rotated with mod-8 addition.
- `hold_cnt` width is 8 bits.

## Test plan
- Fixed priority, `RR_MODE`=0: `req_n`=8'b1010_1111, `ei_n`=0. `gnt`=8'h40 and `gnt_id`=6, two cycles after `req_n` is applied.
- Release and handoff: owner 6 releases while req 4 is held. `gnt`=0 for 2 cycles, then `gnt`=8'h10 with `gnt_id`=4.
- Round-robin, `RR_MODE`=1: all eight requesters pulse release after each grant. The grant sequence is 7,6,5,4,3,2,1,0,7.
- Timeout, `MAX_HOLD`=4: req 3 is held forever. `gnt_valid` is high for 4 cycles, then `timeout`=1 for one cycle. Req 3 is not re-granted until `req_n[3]` toggles high and back low.
- Enable:
  - `ei_n`=1 with `req_n`=8'h00 gives `gnt`=0, `gs_n`=1, `eo_n`=1.
  - `ei_n`=0 with `req_n`=8'hFF gives `eo_n`=0, `gs_n`=1.
  - Raising `ei_n` mid-GRANT keeps `gnt` unchanged until release.
- Reset mid-GRANT: `rst`=1 for 1 cycle while owner 5 holds. The next cycle shows `gnt`=0, `gnt_valid`=0, `gs_n`=1, `eo_n`=1, and the round-robin order restarts from 7.
